// File: rtl/procesador_mc_if.sv
// rtl/procesador_mc_if.sv - memory bus and status signals between procesador_mc and its word memory
interface procesador_mc_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] Address;
    logic [31:0]       Data_in;
    logic [31:0]       Data_out;
    logic              We;
    logic              Halted;
    logic              Illegal;

    modport master (
        input  Data_in,
        output Address, Data_out, We, Halted, Illegal
    );

    modport slave (
        output Data_in,
        input  Address, Data_out, We, Halted, Illegal
    );
endinterface

// File: rtl/procesador_mc.sv
// rtl/procesador_mc.sv - multicycle RV32I-subset core; macro PROC_BRANCH_EN adds BEQ/BNE
module procesador_mc #(
    parameter int          ADDR_W   = 6,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic           Clk,
    input  logic           Reset,
    procesador_mc_if.master bus
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    typedef enum logic [3:0] {C_ILL, C_LUI, C_JAL, C_LW, C_SW, C_ALUI, C_ALUR, C_BR, C_ECALL} iclass_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, ir_q, a_q, b_q, alu_q, mdr_q;
    logic        illegal_q;
    logic [31:0] regs_q [32];

    iclass_t     cls;
    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, op2, alu_res;
    logic        store_now;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign f3     = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign f7     = ir_q[31:25];
    assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    assign imm_u  = {ir_q[31:12], 12'b0};

    always_comb begin
        cls = C_ILL;
        case (opcode)
            7'b0110111: cls = C_LUI;
            7'b1101111: cls = C_JAL;
            7'b0000011: if (f3 == 3'b010) cls = C_LW;
            7'b0100011: if (f3 == 3'b010) cls = C_SW;
            7'b0010011: if (f3 != 3'b001 && f3 != 3'b011 && f3 != 3'b101) cls = C_ALUI;
            7'b0110011: if ((f7 == 7'b0000000 && f3 != 3'b011) ||
                            (f7 == 7'b0100000 && f3 == 3'b000)) cls = C_ALUR;
`ifdef PROC_BRANCH_EN
            7'b1100011: if (f3 == 3'b000 || f3 == 3'b001) cls = C_BR;
`endif
            7'b1110011: if (ir_q == 32'h0000_0073) cls = C_ECALL;
            default:    cls = C_ILL;
        endcase
    end

    always_comb begin
        op2     = (cls == C_ALUR) ? b_q : imm_i;
        alu_res = a_q + op2;
        case (f3)
            3'b000:  alu_res = (cls == C_ALUR && f7[5]) ? a_q - op2 : a_q + op2;
            3'b111:  alu_res = a_q & op2;
            3'b110:  alu_res = a_q | op2;
            3'b100:  alu_res = a_q ^ op2;
            3'b010:  alu_res = {31'b0, $signed(a_q) < $signed(op2)};
            3'b001:  alu_res = a_q << op2[4:0];
            3'b101:  alu_res = a_q >> op2[4:0];
            default: alu_res = a_q + op2;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = (cls == C_ILL || cls == C_ECALL) ? S_HALT : S_EXEC;
            S_EXEC:   state_d = (cls == C_LW || cls == C_SW) ? S_MEM :
                                (cls == C_BR) ? S_FETCH : S_WB;
            S_MEM:    state_d = (cls == C_LW) ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Reset gates the strobe combinationally so a store in the reset cycle never lands.
    assign store_now    = (state_q == S_MEM) && (cls == C_SW) && !Reset;
    assign bus.We       = store_now;
    assign bus.Data_out = store_now ? b_q : 32'h0;
    assign bus.Address  = (state_q == S_MEM) ? alu_q[ADDR_W+1:2] : pc_q[ADDR_W+1:2];
    assign bus.Halted   = (state_q == S_HALT);
    assign bus.Illegal  = illegal_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q      <= RESET_PC;
            ir_q      <= 32'h0;
            a_q       <= 32'h0;
            b_q       <= 32'h0;
            alu_q     <= 32'h0;
            mdr_q     <= 32'h0;
            illegal_q <= 1'b0;
            for (int i = 0; i < 32; i++) regs_q[i] <= 32'h0;
        end else begin
            case (state_q)
                S_FETCH: ir_q <= bus.Data_in;
                S_DECODE: begin
                    a_q       <= (rs1 == 5'd0) ? 32'h0 : regs_q[rs1];
                    b_q       <= (rs2 == 5'd0) ? 32'h0 : regs_q[rs2];
                    illegal_q <= (cls == C_ILL);
                end
                S_EXEC: begin
                    pc_q <= pc_q + 32'd4;
                    case (cls)
                        C_LUI: alu_q <= imm_u;
                        C_JAL: begin
                            alu_q <= pc_q + 32'd4;
                            pc_q  <= pc_q + imm_j;
                        end
                        C_LW:  alu_q <= a_q + imm_i;
                        C_SW:  alu_q <= a_q + imm_s;
                        // f3[0] distinguishes BNE from BEQ
                        C_BR:  if ((a_q == b_q) ^ f3[0]) pc_q <= pc_q + imm_b;
                        default: alu_q <= alu_res;
                    endcase
                end
                S_MEM: if (cls == C_LW) mdr_q <= bus.Data_in;
                S_WB:  if (rd != 5'd0) regs_q[rd] <= (cls == C_LW) ? mdr_q : alu_q;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_procesador_mc.sv
// tb/tb_procesador_mc.sv - table-driven program bench for procesador_mc
module tb_procesador_mc;
    logic clk = 1'b0;
    logic rst;
    logic load;
    logic [31:0] mem [64];
    logic [31:0] img [64];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    procesador_mc_if #(.ADDR_W(6)) bus ();

    procesador_mc #(.ADDR_W(6), .RESET_PC(32'h0)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    assign bus.Data_in = mem[bus.Address];

    always @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < 64; k++) mem[k] <= img[k];
        end else if (bus.We) begin
            mem[bus.Address] <= bus.Data_out;
        end
    end

    typedef struct {
        logic [7:0][31:0] prog;
        int               cycles;
        logic             illegal;
        logic [31:0]      res0;
        logic [31:0]      res1;
        int               we_cnt;
        logic [5:0]       we_addr;
        logic [31:0]      we_data;
        logic [5:0]       halt_addr;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm[11:0], r1, f3, rd, op};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] r1, input logic [31:0] imm);
        return enc_i(imm, r1, 3'b000, rd, 7'b0010011);
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, r2, r1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] sw(input logic [4:0] r2, input logic [4:0] r1, input logic [31:0] imm);
        return {imm[11:5], r2, r1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] r1, input logic [31:0] imm);
        return enc_i(imm, r1, 3'b010, rd, 7'b0000011);
    endfunction
    function automatic logic [31:0] jal(input logic [4:0] rd, input logic [31:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] beq(input logic [4:0] r2, input logic [4:0] r1, input logic [31:0] imm);
        return {imm[12], imm[10:5], r2, r1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction
    localparam logic [31:0] ECALL = 32'h0000_0073;
    localparam logic [31:0] FILL  = 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_and_reset(input logic [7:0][31:0] prog);
        rst = 1'b1;
        for (int k = 0; k < 64; k++) img[k] = (k < 8) ? prog[k] : FILL;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cnt;
        int wes;
        logic [5:0]  fa;
        logic [31:0] fd;
        logic [5:0]  ha;
        string tag;
        tag = $sformatf("v%0d", idx);
        load_and_reset(v.prog);
        cnt = 0; wes = 0; fa = '0; fd = '0;
        while (!bus.Halted && cnt < 200) begin
            if (bus.We) begin
                if (wes == 0) begin fa = bus.Address; fd = bus.Data_out; end
                wes++;
            end
            @(negedge clk);
            cnt++;
        end
        check({tag, " cycles"}, cnt, v.cycles);
        check({tag, " illegal"}, {31'b0, bus.Illegal}, {31'b0, v.illegal});
        ha = bus.Address;
        check({tag, " halt_addr"}, {26'b0, ha}, {26'b0, v.halt_addr});
        repeat (3) begin
            @(negedge clk);
            if (bus.We) wes++;
        end
        check({tag, " halt_hold"}, {26'b0, bus.Address}, {26'b0, ha});
        check({tag, " we_cnt"}, wes, v.we_cnt);
        if (v.we_cnt > 0) begin
            check({tag, " we_addr"}, {26'b0, fa}, {26'b0, v.we_addr});
            check({tag, " we_data"}, fd, v.we_data);
        end
        check({tag, " res0"}, mem[32], v.res0);
        check({tag, " res1"}, mem[33], v.res1);
    endtask

    initial begin
        rst = 1'b1;
        load = 1'b0;
        for (int k = 0; k < 64; k++) img[k] = FILL;

        vecs[0] = '{prog: '0, cycles: 14, illegal: 0, res0: 32'hFFFF_FFFE, res1: FILL,
                    we_cnt: 1, we_addr: 6'd32, we_data: 32'hFFFF_FFFE, halt_addr: 6'd3};
        vecs[0].prog[0] = addi(1, 0, 5);
        vecs[0].prog[1] = addi(2, 1, -7);
        vecs[0].prog[2] = sw(2, 0, 128);
        vecs[0].prog[3] = ECALL;

        vecs[1] = '{prog: '0, cycles: 23, illegal: 0, res0: 32'hFFFF_FFFE, res1: FILL,
                    we_cnt: 2, we_addr: 6'd2, we_data: 32'hFFFF_FFFE, halt_addr: 6'd5};
        vecs[1].prog[0] = addi(1, 0, 5);
        vecs[1].prog[1] = addi(2, 1, -7);
        vecs[1].prog[2] = sw(2, 0, 8);
        vecs[1].prog[3] = lw(3, 0, 8);
        vecs[1].prog[4] = sw(3, 0, 128);
        vecs[1].prog[5] = ECALL;

        vecs[2] = '{prog: '0, cycles: 26, illegal: 0, res0: 32'h0, res1: 32'hFFFF_FFFB,
                    we_cnt: 2, we_addr: 6'd32, we_data: 32'h0, halt_addr: 6'd6};
        vecs[2].prog[0] = addi(0, 0, 9);
        vecs[2].prog[1] = enc_r(7'h00, 0, 0, 3'b000, 4);
        vecs[2].prog[2] = sw(4, 0, 128);
        vecs[2].prog[3] = addi(1, 0, 5);
        vecs[2].prog[4] = enc_r(7'h20, 1, 0, 3'b000, 5);
        vecs[2].prog[5] = sw(5, 0, 132);
        vecs[2].prog[6] = ECALL;

        vecs[3] = '{prog: '0, cycles: 18, illegal: 0, res0: 32'h14, res1: FILL,
                    we_cnt: 1, we_addr: 6'd32, we_data: 32'h14, halt_addr: 6'd2};
        vecs[3].prog[0] = jal(0, 16);
        vecs[3].prog[1] = sw(1, 0, 128);
        vecs[3].prog[2] = ECALL;
        vecs[3].prog[3] = jal(0, -8);
        vecs[3].prog[4] = jal(1, -4);

        vecs[4] = '{prog: '0, cycles: 26, illegal: 0, res0: 32'h1FFF_FFFF, res1: 32'h1,
                    we_cnt: 2, we_addr: 6'd32, we_data: 32'h1FFF_FFFF, halt_addr: 6'd6};
        vecs[4].prog[0] = addi(1, 0, -1);
        vecs[4].prog[1] = addi(2, 0, 3);
        vecs[4].prog[2] = enc_r(7'h00, 2, 1, 3'b101, 3);
        vecs[4].prog[3] = enc_r(7'h00, 2, 1, 3'b010, 5);
        vecs[4].prog[4] = sw(3, 0, 128);
        vecs[4].prog[5] = sw(5, 0, 132);
        vecs[4].prog[6] = ECALL;

        vecs[5] = '{prog: '0, cycles: 26, illegal: 0, res0: 32'hEDCB_AFFF, res1: 32'h7FF,
                    we_cnt: 2, we_addr: 6'd32, we_data: 32'hEDCB_AFFF, halt_addr: 6'd6};
        vecs[5].prog[0] = {20'h12345, 5'd1, 7'b0110111};
        vecs[5].prog[1] = enc_i(-1, 1, 3'b100, 2, 7'b0010011);
        vecs[5].prog[2] = enc_i(32'h0F0, 2, 3'b111, 3, 7'b0010011);
        vecs[5].prog[3] = enc_i(32'h70F, 3, 3'b110, 4, 7'b0010011);
        vecs[5].prog[4] = sw(2, 0, 128);
        vecs[5].prog[5] = sw(4, 0, 132);
        vecs[5].prog[6] = ECALL;

        vecs[6] = '{prog: '0, cycles: 6, illegal: 1, res0: FILL, res1: FILL,
                    we_cnt: 0, we_addr: 6'd0, we_data: 32'h0, halt_addr: 6'd1};
        vecs[6].prog[0] = addi(1, 0, 1);
        vecs[6].prog[1] = enc_i(32'h1, 1, 3'b001, 1, 7'b0010011);

`ifdef PROC_BRANCH_EN
        vecs[7] = '{prog: '0, cycles: 13, illegal: 0, res0: 32'h7, res1: FILL,
                    we_cnt: 1, we_addr: 6'd32, we_data: 32'h7, halt_addr: 6'd4};
`else
        vecs[7] = '{prog: '0, cycles: 2, illegal: 1, res0: FILL, res1: FILL,
                    we_cnt: 0, we_addr: 6'd0, we_data: 32'h0, halt_addr: 6'd0};
`endif
        vecs[7].prog[0] = beq(0, 0, 8);
        vecs[7].prog[1] = ECALL;
        vecs[7].prog[2] = addi(1, 0, 7);
        vecs[7].prog[3] = sw(1, 0, 128);
        vecs[7].prog[4] = ECALL;

        vecs[8] = '{prog: '0, cycles: 19, illegal: 0, res0: 32'h55, res1: 32'h55,
                    we_cnt: 2, we_addr: 6'd32, we_data: 32'h55, halt_addr: 6'd4};
        vecs[8].prog[0] = addi(1, 0, 32'h55);
        vecs[8].prog[1] = sw(1, 0, 386);
        vecs[8].prog[2] = lw(3, 0, 128);
        vecs[8].prog[3] = sw(3, 0, 132);
        vecs[8].prog[4] = ECALL;

        // Reset-state outputs
        repeat (2) @(negedge clk);
        check("rst halted", {31'b0, bus.Halted}, 32'h0);
        check("rst illegal", {31'b0, bus.Illegal}, 32'h0);
        check("rst we", {31'b0, bus.We}, 32'h0);
        check("rst data_out", bus.Data_out, 32'h0);
        check("rst address", {26'b0, bus.Address}, 32'h0);

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

        // Reset landing on the MEM cycle of a store must suppress the write
        begin
            logic [7:0][31:0] p;
            p = '0;
            p[0] = addi(1, 0, 1);
            p[1] = sw(1, 0, 128);
            p[2] = ECALL;
            load_and_reset(p);
            repeat (7) @(negedge clk);
            check("mem_cycle we", {31'b0, bus.We}, 32'h1);
            check("mem_cycle addr", {26'b0, bus.Address}, 32'd32);
            rst = 1'b1;
            #1;
            check("rst_gate we", {31'b0, bus.We}, 32'h0);
            @(negedge clk);
            rst = 1'b0;
            check("post_rst addr", {26'b0, bus.Address}, 32'h0);
            check("post_rst halted", {31'b0, bus.Halted}, 32'h0);
            check("post_rst mem", mem[32], FILL);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/procesador_mc.md
PROCESADOR_MC -- requirements
Module: procesador_mc

Interface
REQ-001 Parameter ADDR_W, default 6, SHALL set the memory word-address width (2^ADDR_W words of 32 bits).
REQ-002 Parameter RESET_PC, default 0, SHALL set the byte PC loaded on reset.
REQ-003 Clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 Reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 Data_in  input  32  SHALL carry the memory read word, valid combinationally in the same cycle as Address (asynchronous-read memory).
REQ-006 Address  output  ADDR_W  SHALL carry the word address: byte_addr[ADDR_W+1:2].
REQ-007 Data_out  output  32  SHALL carry store data, meaningful only while We=1.
REQ-008 We  output  1  SHALL request a memory write of Data_out at Address on the next rising edge.
REQ-009 Halted  output  1  SHALL be 1 while the core is stopped.
REQ-010 Illegal  output  1  SHALL be 1 when the halt was caused by an unsupported encoding.

Function
REQ-011 The core SHALL be a non-pipelined multicycle RV32I subset with state machine FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-012 FETCH SHALL drive Address=PC[ADDR_W+1:2] and latch Data_in into IR, then go to DECODE.
REQ-013 DECODE SHALL read rs1/rs2 from a 32x32 register file into A/B; x0 SHALL always read 0, and writes to x0 SHALL be discarded.
REQ-014 Supported: LUI, JAL, LW, SW, ADDI, ANDI, ORI, XORI, SLTI, ADD, SUB, AND, OR, XOR, SLT, SLL, SRL, ECALL; any other encoding SHALL go to HALT with Illegal=1.
REQ-015 ALU ops SHALL use 32-bit wrap-around arithmetic; SLT/SLTI SHALL compare signed; shifts SHALL use B[4:0]; I-immediates SHALL be sign-extended.
REQ-016 Cycle counts SHALL be: ALU/LUI/JAL 4 (F,D,E,WB); LW 5 (F,D,E,M,WB); SW 4 (F,D,E,M); branch 3 (F,D,E).
REQ-017 PC SHALL advance by 4 (wrapping at 2^32) at EXEC, except for a taken JAL/branch, where PC = PC + sign-extended offset; JAL SHALL write PC+4 to rd.
REQ-018 LW/SW effective byte address SHALL be A + imm; bits [1:0] SHALL be ignored (word access only); bits above ADDR_W+1 SHALL be ignored (address aliasing).
REQ-019 SW SHALL assert We=1 with Data_out=B for exactly one cycle (MEM); We SHALL be 0 in all other states.
REQ-020 LW SHALL latch Data_in in MEM and write it to rd in WB.
REQ-021 ECALL SHALL enter HALT with Illegal=0; HALT SHALL be left only by Reset, with Address held at the last PC word and We=0.
REQ-022 An instruction SHALL modify memory (We) in MEM or write the register file in WB only; no architectural state changes in FETCH or DECODE.

Reset
REQ-023 Reset asserted at any edge SHALL abort the current instruction and set PC=RESET_PC, state=FETCH, We=0, Data_out=0, Halted=0, Illegal=0, IR=0, and all registers to 0.
REQ-024 Reset SHALL override a concurrent store: no write occurs in the cycle in which Reset is sampled high.

Configuration
REQ-025 With macro PROC_BRANCH_EN defined, BEQ and BNE SHALL be supported: compare A==B in EXEC; if taken, PC=PC+B-imm, else PC=PC+4.
REQ-026 Without PROC_BRANCH_EN, BEQ/BNE encodings SHALL be treated as illegal per REQ-014.

Verification
REQ-027 ADDI x1,x0,5; ADDI x2,x1,-7 -> x2=0xFFFFFFFE; each instruction takes 4 cycles; We stays 0.
REQ-028 SW x2,8(x0) then LW x3,8(x0) -> We=1 for one cycle with Address=2 and Data_out=0xFFFFFFFE; x3=0xFFFFFFFE after 5 cycles.
REQ-029 ADDI x0,x0,9 followed by ADD x4,x0,x0 -> x4=0.
REQ-030 JAL x1,-4 at PC=0x10 -> PC=0x0C, x1=0x14.
REQ-031 With PROC_BRANCH_EN: BEQ x0,x0,+8 at PC=0 -> next fetch at Address=2; without the macro: Halted=1, Illegal=1.
REQ-032 Reset pulsed during the MEM cycle of SW -> no write; next cycle Address=RESET_PC[ADDR_W+1:2], Halted=0.
